// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM fader: ramps each channel's duty toward
// full-on/full-off at a prescaled step rate and drives registered PWM.
module led_pwm_fader #(
  parameter int CHANNELS  = 4,
  parameter int PWM_WIDTH = 8,
  parameter int STEP_DIV  = 97_656,
  parameter int STEP_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] pattern_in,
  output logic [CHANNELS-1:0] led_out,
  output logic                busy
);

  localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_WIDTH-1:0] FULL = '1;
  localparam logic [PW-1:0] DIV_LAST = PW'(STEP_DIV - 1);
  localparam logic [PWM_WIDTH:0] STEP_W = (PWM_WIDTH + 1)'(STEP_SIZE);

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RISE,
    CH_ON,
    CH_FALL
  } ch_state_e;

  logic [PW-1:0]        r_presc;
  logic [PWM_WIDTH-1:0] r_pwm_cnt;
  logic [CHANNELS-1:0]  r_pat_q;
  logic [CHANNELS-1:0]  r_led;
  logic [PWM_WIDTH-1:0] r_duty     [CHANNELS];

  logic                 w_tick;
  logic                 w_busy;
  ch_state_e            w_state    [CHANNELS];
  logic [PWM_WIDTH-1:0] w_target   [CHANNELS];
  logic [PWM_WIDTH:0]   w_sum      [CHANNELS];
  logic [PWM_WIDTH-1:0] w_duty_nxt [CHANNELS];

  assign w_tick  = (r_presc == DIV_LAST);
  assign led_out = r_led;
  assign busy    = w_busy;

  // Channel state is purely a function of duty vs. target.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_target[i]   = r_pat_q[i] ? FULL : '0;
      w_state[i]    = CH_OFF;
      w_sum[i]      = {1'b0, r_duty[i]} + STEP_W;
      w_duty_nxt[i] = r_duty[i];
      if (r_duty[i] < w_target[i])
        w_state[i] = CH_RISE;
      else if (r_duty[i] > w_target[i])
        w_state[i] = CH_FALL;
      else if (r_duty[i] == FULL)
        w_state[i] = CH_ON;
      unique case (w_state[i])
        CH_RISE: begin
          if (w_sum[i] > {1'b0, FULL})
            w_duty_nxt[i] = FULL;
          else
            w_duty_nxt[i] = w_sum[i][PWM_WIDTH-1:0];
        end
        CH_FALL: begin
          if ({1'b0, r_duty[i]} < STEP_W)
            w_duty_nxt[i] = '0;
          else
            w_duty_nxt[i] = r_duty[i] - STEP_W[PWM_WIDTH-1:0];
        end
        default: w_duty_nxt[i] = r_duty[i];
      endcase
      if (w_state[i] == CH_RISE || w_state[i] == CH_FALL)
        w_busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
      r_pat_q   <= '0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
      r_pat_q   <= pattern_in;
    end
  end

  // Full duty forces a solid-on output instead of 255/256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
      for (int i = 0; i < CHANNELS; i++)
        r_duty[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_tick)
          r_duty[i] <= w_duty_nxt[i];
        r_led[i] <= (r_duty[i] == FULL) || (r_pwm_cnt < r_duty[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: reset, ramps, reversal,
// PWM duty and asynchronous reset behaviour.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pat = 4'h0;
  logic [3:0] led;
  logic       busy;
  logic [1:0] h_pat = 2'b01;
  logic [1:0] h_led;
  logic       h_busy;

  int errs = 0;
  int checks = 0;
  int k = 0;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .CHANNELS(4), .PWM_WIDTH(8), .STEP_DIV(4), .STEP_SIZE(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pattern_in(pat),
    .led_out(led), .busy(busy)
  );

  // Slow-step instance: holds duty 128 long enough to measure PWM.
  led_pwm_fader #(
    .CHANNELS(2), .PWM_WIDTH(8), .STEP_DIV(1000), .STEP_SIZE(128)
  ) u_hold (
    .clk(clk), .rst_n(rst_n), .pattern_in(h_pat),
    .led_out(h_led), .busy(h_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_duty(input string tag, input int d0, input int d1,
                          input int d2, input int d3);
    chk({tag, "_d0"}, 32'(dut.r_duty[0]), d0);
    chk({tag, "_d1"}, 32'(dut.r_duty[1]), d1);
    chk({tag, "_d2"}, 32'(dut.r_duty[2]), d2);
    chk({tag, "_d3"}, 32'(dut.r_duty[3]), d3);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic next_tick();
    step(1);
    while (k % 4 != 0) step(1);
  endtask

  initial begin
    int bad;
    int cnt;

    // Reset state with a non-zero pattern applied
    pat = 4'hF;
    step(3);
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk_duty("rst", 0, 0, 0, 0);
    chk("rst_hled", 32'(h_led), 0);

    pat = 4'h0;
    rst_n = 1'b1;
    k = 0;

    // Idle pattern for 2000 cycles; slow instance measured meanwhile
    bad = 0;
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (led !== 4'h0 || busy !== 1'b0) bad++;
      if (k >= 1010 && k < 1266 && h_led[0] === 1'b1) cnt++;
      if (k == 1500) chk("hold_busy", 32'(h_busy), 1);
      if (k == 1500) chk("hold_led1", 32'(h_led[1]), 0);
    end
    chk("idle_bad_cycles", bad, 0);
    chk("hold_pwm128_high", cnt, 128);

    // Rising ramp on channel 0
    pat = 4'b0001;
    chk("rise_busy_pre", 32'(busy), 0);
    step(1);
    chk("rise_busy_next", 32'(busy), 1);
    chk("rise_d0_pre", 32'(dut.r_duty[0]), 0);
    step(3);
    chk("rise_t1", 32'(dut.r_duty[0]), 64);
    next_tick();
    chk("rise_t2", 32'(dut.r_duty[0]), 128);
    next_tick();
    chk("rise_t3", 32'(dut.r_duty[0]), 192);
    next_tick();
    chk("rise_t4", 32'(dut.r_duty[0]), 255);
    chk("rise_busy_done", 32'(busy), 0);
    step(1);
    bad = 0;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      if (led[0] === 1'b1) cnt++;
      if (led[3:1] !== 3'b000) bad++;
    end
    chk("full_led0_high", cnt, 256);
    chk("full_others_bad", bad, 0);

    // All on, then channel 3 falls
    next_tick();
    pat = 4'b1111;
    repeat (4) next_tick();
    chk_duty("allon", 255, 255, 255, 255);
    chk("allon_busy", 32'(busy), 0);
    pat = 4'b0111;
    next_tick();
    chk_duty("fall1", 255, 255, 255, 191);
    next_tick();
    chk_duty("fall2", 255, 255, 255, 127);
    next_tick();
    chk_duty("fall3", 255, 255, 255, 63);
    next_tick();
    chk_duty("fall4", 255, 255, 255, 0);
    step(1);
    bad = 0;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      if (led[3] === 1'b1) cnt++;
      if (led[2:0] !== 3'b111) bad++;
    end
    chk("off_led3_high", cnt, 0);
    chk("off_others_bad", bad, 0);

    // Simultaneous rise/fall, then direction reversal mid-ramp
    next_tick();
    pat = 4'b1100;
    next_tick();
    chk_duty("mix1", 191, 191, 255, 64);
    next_tick();
    chk_duty("mix2", 127, 127, 255, 128);
    pat = 4'b0011;
    next_tick();
    chk_duty("rev1", 191, 191, 191, 64);
    next_tick();
    chk_duty("rev2", 255, 255, 127, 0);
    next_tick();
    next_tick();
    chk_duty("rev4", 255, 255, 0, 0);
    chk("rev_busy", 32'(busy), 0);

    // Rising at 128, then cleared: no overshoot
    pat = 4'b0111;
    next_tick();
    next_tick();
    chk("ovr_up", 32'(dut.r_duty[2]), 128);
    pat = 4'b0011;
    next_tick();
    chk("ovr_dn1", 32'(dut.r_duty[2]), 64);
    next_tick();
    chk("ovr_dn2", 32'(dut.r_duty[2]), 0);
    next_tick();
    chk("ovr_hold", 32'(dut.r_duty[2]), 0);
    chk("ovr_busy", 32'(busy), 0);

    // Asynchronous reset mid-ramp
    pat = 4'b1100;
    next_tick();
    chk_duty("pre_rst", 191, 191, 64, 64);
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(led), 0);
    chk("arst_busy", 32'(busy), 0);
    chk_duty("arst", 0, 0, 0, 0);
    chk("arst_hled", 32'(h_led), 0);
    #3;
    rst_n = 1'b1;
    k = 0;
    step(3);
    chk_duty("rel_pre", 0, 0, 0, 0);
    chk("rel_busy", 32'(busy), 1);
    step(1);
    chk_duty("rel_t1", 0, 0, 64, 64);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
